// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The packer and the top-level FSM both import this package.
package instr_mem_loader_pkg;

   localparam int WORD     = 32;
   localparam int BYTE     = 8;
   localparam int INS_SIZE = 256;

   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_LEN   = 3'd1,
      LD_DATA  = 3'd2,
      LD_WRITE = 3'd3,
      LD_DONE  = 3'd4,
      LD_ERR   = 3'd5
   } ld_state_t;

   // The CPU stays stalled for the whole session, including after an
   // overflow, and is released only once a load has completed.
   function automatic logic holds_cpu(input ld_state_t s);
      return (s == LD_LEN) || (s == LD_DATA) || (s == LD_WRITE) || (s == LD_ERR);
   endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte accepted lands in the top byte.
// Used for both the length header and the data words.
module instr_mem_loader_byte_packer
   import instr_mem_loader_pkg::*;
#(
   parameter int WORD_W = WORD,
   parameter int BYTE_W = BYTE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word_next,
   output logic              word_full
);

   localparam int CNT_W = $clog2(WORD_W / BYTE_W);

   logic [WORD_W-1:0] word;
   logic [CNT_W-1:0]  cnt;

   // word_next is what the register holds after this byte is taken, so the
   // completed word is visible in the same cycle as its last byte.
   assign word_next = {word[WORD_W-BYTE_W-1:0], byte_in};
   assign word_full = shift_en && (cnt == {CNT_W{1'b1}});

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         word <= '0;
         cnt  <= '0;
      end else if (shift_en) begin
         word <= word_next;
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction RAM writer: length-prefixed byte stream in, one RAM word write
// per four data bytes out; holds the CPU while a load is in progress.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int WORD_W = WORD,
   parameter int BYTE_W = BYTE,
   parameter int DEPTH  = INS_SIZE,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   ld_state_t         state, state_next;
   logic [WORD_W-1:0] len;
   logic [WORD_W-1:0] pk_word;
   logic              pk_full;
   logic              accept;
   logic              sess_start;
   logic [ADDR_W:0]   wl_inc;

   assign accept = byte_valid && byte_ready;
   assign wl_inc = words_loaded + 1'b1;

   instr_mem_loader_byte_packer #(
      .WORD_W (WORD_W),
      .BYTE_W (BYTE_W)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (sess_start),
      .shift_en  (accept),
      .byte_in   (byte_in),
      .word_next (pk_word),
      .word_full (pk_full)
   );

   always_comb begin
      state_next = state;
      sess_start = 1'b0;
      case (state)
         LD_IDLE, LD_DONE, LD_ERR: begin
            if (start) begin
               state_next = LD_LEN;
               sess_start = 1'b1;
            end
         end
         LD_LEN: begin
            if (pk_full) begin
               if (pk_word == '0)
                  state_next = LD_DONE;
               else if (pk_word > WORD_W'(DEPTH))
                  state_next = LD_ERR;
               else
                  state_next = LD_DATA;
            end
         end
         LD_DATA: begin
            if (pk_full)
               state_next = LD_WRITE;
         end
         LD_WRITE: begin
            state_next = (WORD_W'(wl_inc) == len) ? LD_DONE : LD_DATA;
         end
         default: state_next = LD_IDLE;
      endcase
   end

   assign byte_ready = (state == LD_LEN) || (state == LD_DATA);
   assign wr_en      = (state == LD_WRITE);
   assign cpu_hold   = holds_cpu(state);
   assign done       = (state == LD_DONE);
   assign error      = (state == LD_ERR);

   // wr_addr/wr_data are loaded as the last byte of a word arrives so they are
   // stable for the whole WRITE cycle and hold afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LD_IDLE;
         len          <= '0;
         words_loaded <= '0;
         wr_addr      <= '0;
         wr_data      <= '0;
      end else begin
         state <= state_next;
         if (sess_start) begin
            len          <= '0;
            words_loaded <= '0;
         end
         if ((state == LD_LEN) && pk_full)
            len <= pk_word;
         if ((state == LD_DATA) && pk_full) begin
            wr_addr <= words_loaded[ADDR_W-1:0];
            wr_data <= pk_word;
         end
         if (state == LD_WRITE)
            words_loaded <= wl_inc;
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a small RAM (DEPTH=16) so the
// full-fill and overflow cases stay short.
module tb_instr_mem_loader;

   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        byte_in = '0;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int tests = 0;
   int fails = 0;

   logic [ADDR_W-1:0] log_addr[$];
   logic [31:0]       log_data[$];
   int                log_acc[$];
   int                acc_cnt = 0;

   instr_mem_loader #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .byte_ready   (byte_ready),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Bytes accepted since the last start pulse, and a log of every RAM write.
   always @(posedge clk) begin
      if (start)
         acc_cnt <= 0;
      else if (byte_valid && byte_ready)
         acc_cnt <= acc_cnt + 1;
   end

   always @(negedge clk) begin
      if (wr_en) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
         log_acc.push_back(acc_cnt);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      if (gap) begin
         byte_valid = 1'b0;
         step($urandom_range(1, 3));
      end
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      while (!byte_ready && n < 50) begin
         step(1);
         n++;
      end
      if (!byte_ready) begin
         tests++;
         fails++;
         $error("FAIL ready_timeout observed=0 expected=1");
      end
      step(1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8],  gap);
      send_byte(w[7:0],   gap);
   endtask

   initial begin : stim
      int base;
      int bad;

      // Reset state
      step(2);
      rst = 1'b0;
      check("rst_ready",  byte_ready,   0);
      check("rst_hold",   cpu_hold,     0);
      check("rst_done",   done,         0);
      check("rst_error",  error,        0);
      check("rst_wren",   wr_en,        0);
      check("rst_wl",     words_loaded, 0);
      check("rst_waddr",  wr_addr,      0);
      check("rst_wdata",  wr_data,      0);

      // 1. Basic load
      pulse_start();
      check("t1_hold_on", cpu_hold, 1);
      check("t1_ready",   byte_ready, 1);
      base = log_addr.size();
      send_word(32'h0000_0002, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      check("t1_wren_w0", wr_en, 1);
      send_word(32'h1234_5678, 1'b0);
      byte_valid = 1'b0;
      step(1);
      check("t1_done",   done,         1);
      check("t1_wl",     words_loaded, 2);
      check("t1_hold",   cpu_hold,     0);
      check("t1_nwr",    log_addr.size() - base, 2);
      check("t1_a0",     log_addr[base],   0);
      check("t1_d0",     log_data[base],   32'hDEAD_BEEF);
      check("t1_a1",     log_addr[base+1], 1);
      check("t1_d1",     log_data[base+1], 32'h1234_5678);

      // 2. Gapped stream
      pulse_start();
      check("t2_done_clr", done, 0);
      base = log_addr.size();
      send_word(32'h0000_0002, 1'b1);
      send_word(32'hDEAD_BEEF, 1'b1);
      send_word(32'h1234_5678, 1'b1);
      byte_valid = 1'b0;
      step(1);
      check("t2_done", done,         1);
      check("t2_wl",   words_loaded, 2);
      check("t2_nwr",  log_addr.size() - base, 2);
      check("t2_a0",   log_addr[base],   0);
      check("t2_d0",   log_data[base],   32'hDEAD_BEEF);
      check("t2_acc0", log_acc[base],    8);
      check("t2_a1",   log_addr[base+1], 1);
      check("t2_d1",   log_data[base+1], 32'h1234_5678);
      check("t2_acc1", log_acc[base+1],  12);

      // 3. Zero length
      pulse_start();
      base = log_addr.size();
      send_word(32'h0000_0000, 1'b0);
      byte_valid = 1'b0;
      check("t3_done", done,         1);
      check("t3_wl",   words_loaded, 0);
      step(3);
      check("t3_nwr",  log_addr.size() - base, 0);

      // 4. Overflow, then recovery
      pulse_start();
      base = log_addr.size();
      send_word(32'h0000_0011, 1'b0);
      byte_valid = 1'b0;
      check("t4_error", error,      1);
      check("t4_hold",  cpu_hold,   1);
      check("t4_ready", byte_ready, 0);
      check("t4_done",  done,       0);
      step(3);
      check("t4_nwr",   log_addr.size() - base, 0);
      pulse_start();
      check("t4_err_clr", error, 0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      byte_valid = 1'b0;
      step(1);
      check("t4_error2", error, 0);
      check("t4_done2",  done,  1);
      check("t4_nwr2",   log_addr.size() - base, 1);
      check("t4_a0",     log_addr[base], 0);
      check("t4_d0",     log_data[base], 32'hCAFE_F00D);

      // 5. Reset mid-word
      pulse_start();
      send_word(32'h0000_0004, 1'b0);
      send_word(32'h1111_1111, 1'b0);
      send_word(32'h2222_2222, 1'b0);
      send_word(32'h3333_3333, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      byte_valid = 1'b0;
      check("t5_wl_pre", words_loaded, 3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("t5_ready", byte_ready,   0);
      check("t5_hold",  cpu_hold,     0);
      check("t5_done",  done,         0);
      check("t5_error", error,        0);
      check("t5_wren",  wr_en,        0);
      check("t5_wl",    words_loaded, 0);
      check("t5_waddr", wr_addr,      0);
      check("t5_wdata", wr_data,      0);
      pulse_start();
      base = log_addr.size();
      send_word(32'h0000_0001, 1'b0);
      send_word(32'h4455_6677, 1'b0);
      byte_valid = 1'b0;
      step(1);
      check("t5_done2", done, 1);
      check("t5_nwr",   log_addr.size() - base, 1);
      check("t5_a0",    log_addr[base], 0);
      check("t5_d0",    log_data[base], 32'h4455_6677);

      // 6. Full RAM, with a start pulse during the load that must be ignored
      pulse_start();
      base = log_addr.size();
      send_word(32'(DEPTH), 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 5) begin
            byte_valid = 1'b0;
            pulse_start();
            check("t6_hold_mid", cpu_hold, 1);
         end
         send_word(32'(i), 1'b0);
      end
      byte_valid = 1'b0;
      step(1);
      check("t6_done", done,         1);
      check("t6_wl",   words_loaded, DEPTH);
      check("t6_nwr",  log_addr.size() - base, DEPTH);
      check("t6_alast", log_addr[base+DEPTH-1], DEPTH - 1);
      check("t6_dlast", log_data[base+DEPTH-1], DEPTH - 1);
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
         if (log_addr[base+i] != ADDR_W'(i) || log_data[base+i] != 32'(i))
            bad++;
      check("t6_all_words", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
